// File: rtl/shift_stage.sv
// Issue/capture stage around the combinational shifter: registers operands,
// waits one cycle for the shifter to settle, then holds result + flags until
// writeback takes them. Define SHIFT_STAGE_FLAGS_EN to build the status flags.
module shift_stage #(
   parameter int BITS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_a,
   input  logic [BITS-1:0] in_b,
   input  logic [2:0]      in_opcode,
   output logic [BITS-1:0] sh_a,
   output logic [BITS-1:0] sh_b,
   output logic [2:0]      sh_opcode,
   input  logic [BITS-1:0] sh_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_result,
   output logic            out_zero,
   output logic            out_neg,
   output logic            out_carry,
   output logic            out_illegal
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic            in_xfer;
   logic [BITS-1:0] res_capt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_xfer = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_a      <= '0;
         sh_b      <= '0;
         sh_opcode <= '0;
      end else if (in_xfer) begin
         sh_a      <= in_a;
         sh_b      <= in_b;
         sh_opcode <= in_opcode;
      end
   end

   // Illegal opcodes report a zero result regardless of what the shifter returns.
   assign res_capt = sh_opcode[2] ? '0 : sh_result;

   always_ff @(posedge clk) begin
      if (rst)                out_result <= '0;
      else if (state == EXEC) out_result <= res_capt;
   end

`ifdef SHIFT_STAGE_FLAGS_EN
   logic lsl_c, lsr_c, big_k, carry_nxt;

   // Last bit shifted out for shift amounts 1..BITS; larger amounts handled below.
   always_comb begin
      lsl_c = 1'b0;
      lsr_c = 1'b0;
      for (int i = 1; i <= BITS; i++) begin
         if (sh_b == BITS'(i)) begin
            lsl_c = sh_a[BITS-i];
            lsr_c = sh_a[i-1];
         end
      end
   end

   assign big_k = (sh_b > BITS'(BITS));

   always_comb begin
      carry_nxt = 1'b0;
      case (sh_opcode)
         3'b000, 3'b010: carry_nxt = lsl_c;
         3'b001:         carry_nxt = lsr_c;
         3'b011:         carry_nxt = big_k ? sh_a[BITS-1] : lsr_c;
         default:        carry_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_zero    <= 1'b0;
         out_neg     <= 1'b0;
         out_carry   <= 1'b0;
         out_illegal <= 1'b0;
      end else if (state == EXEC) begin
         out_zero    <= (res_capt == '0);
         out_neg     <= res_capt[BITS-1];
         out_carry   <= carry_nxt;
         out_illegal <= sh_opcode[2];
      end
   end
`else
   assign out_zero    = 1'b0;
   assign out_neg     = 1'b0;
   assign out_carry   = 1'b0;
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_shift_stage.sv
// Self-checking bench for shift_stage: behavioural shifter, directed table,
// randomized requests against an arithmetic reference model, and handshake corners.
module tb_shift_stage;
   localparam int BITS = 16;
`ifdef SHIFT_STAGE_FLAGS_EN
   localparam logic FE = 1'b1;
`else
   localparam logic FE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0, in_ready;
   logic [BITS-1:0] in_a = '0, in_b = '0;
   logic [2:0]      in_opcode = '0;
   logic [BITS-1:0] sh_a, sh_b, sh_result;
   logic [2:0]      sh_opcode;
   logic            out_valid, out_ready = 1'b0;
   logic [BITS-1:0] out_result;
   logic            out_zero, out_neg, out_carry, out_illegal;

   int checks = 0;
   int errors = 0;

   shift_stage #(.BITS(BITS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
      .sh_a(sh_a), .sh_b(sh_b), .sh_opcode(sh_opcode), .sh_result(sh_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      logic [15:0] res;
      logic        zero, neg, carry, ill;
   } vec_t;

   // Reference: shifts done on 64-bit values so the bit leaving the word lands
   // at a fixed position (bit 16 for left shifts, bit 0 of a pre-shifted copy for right).
   function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      vec_t                 v;
      logic [63:0]          ua, full, r;
      logic signed [63:0]   sa, sfull, sr;
      int unsigned          k;
      ua = {48'd0, a};
      sa = {{48{a[15]}}, a};
      k  = b;
      v.a = a; v.b = b; v.op = op;
      v.res = '0; v.carry = 1'b0; v.ill = op[2];
      if (!op[2]) begin
         case (op[1:0])
            2'b00, 2'b10: begin
               full = (k >= 64) ? 64'd0 : (ua << k);
               v.res = full[15:0]; v.carry = full[16];
            end
            2'b01: begin
               r = ua >> k; full = (ua << 1) >> k;
               v.res = r[15:0]; v.carry = full[0];
            end
            default: begin
               sr = sa >>> k; sfull = (sa <<< 1) >>> k;
               v.res = sr[15:0]; v.carry = (k == 0) ? 1'b0 : sfull[0];
            end
         endcase
      end
      v.zero = (v.res == 16'd0);
      v.neg  = v.res[15];
      return v;
   endfunction

   // Stand-in for the external combinational shifter.
   always_comb begin
      vec_t s;
      s = model(sh_a, sh_b, sh_opcode);
      sh_result = s.res;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, ".result"}, {16'd0, out_result}, {16'd0, v.res});
      chk({tag, ".flags"}, {28'd0, out_zero, out_neg, out_carry, out_illegal},
          {28'd0, v.zero & FE, v.neg & FE, v.carry & FE, v.ill & FE});
   endtask

   // Transfer one request with out_ready low, then confirm the 2-edge latency.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      int n;
      n = 0;
      in_a = a; in_b = b; in_opcode = op; in_valid = 1'b1;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (n >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("exec.out_valid", 32'(out_valid), 32'd0);
      chk("exec.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("latency.out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t tbl[9];
   vec_t v, v2;

   initial begin
      tbl[0] = '{16'h8001, 16'd1,  3'b000, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{16'h8000, 16'd4,  3'b011, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{16'h8000, 16'd20, 3'b011, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{16'h0001, 16'd1,  3'b001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{16'h1234, 16'd3,  3'b101, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{16'h0001, 16'd16, 3'b000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{16'h8000, 16'd16, 3'b001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{16'h8000, 16'd17, 3'b001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{16'hABCD, 16'd0,  3'b010, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0};

      tick(); tick();
      rst = 1'b0;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.sh_a", {16'd0, sh_a}, 32'd0);
      chk("rst.out_result", {16'd0, out_result}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].op);
         check_out($sformatf("tbl%0d", i), tbl[i]);
         consume();
      end

      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra, rb;
         logic [2:0]  rop;
         ra  = 16'($urandom);
         rb  = (i % 5 == 4) ? 16'($urandom) : 16'($urandom_range(0, 20));
         rop = 3'($urandom_range(0, 7));
         v = model(ra, rb, rop);
         issue(ra, rb, rop);
         check_out($sformatf("rnd%0d", i), v);
         consume();
      end

      // Backpressure, then same-edge output and input transfers.
      v  = model(16'h00F3, 16'd2, 3'b001);
      v2 = model(16'h4001, 16'd15, 3'b000);
      issue(v.a, v.b, v.op);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         check_out("bp.hold", v);
      end
      out_ready = 1'b1;
      in_a = v2.a; in_b = v2.b; in_opcode = v2.op; in_valid = 1'b1;
      #1;
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.exec_out_valid", 32'(out_valid), 32'd0);
      chk("b2b.sh_a", {16'd0, sh_a}, {16'd0, v2.a});
      tick();
      chk("b2b.out_valid", 32'(out_valid), 32'd1);
      check_out("b2b", v2);
      consume();
      chk("drain.out_valid", 32'(out_valid), 32'd0);

      // Reset mid-EXEC discards the request.
      in_a = 16'h5555; in_b = 16'd1; in_opcode = 3'b000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstx.out_valid", 32'(out_valid), 32'd0);
      chk("rstx.in_ready", 32'(in_ready), 32'd1);
      chk("rstx.sh_a", {16'd0, sh_a}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstx.no_output", 32'(out_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end
endmodule
